// File: rtl/dual_port_ram_driver_if.sv
// Write/read port bundle for dual_port_ram_driver; master drives requests, slave returns data.
// Pure wiring, no latency; no backpressure signals exist on either side.
interface dual_port_ram_driver_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  readclk;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] win;
  logic                  outclk;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output readclk, raddr, we, waddr, win,
    input  outclk, out
  );

  modport slave (
    input  readclk, raddr, we, waddr, win,
    output outclk, out
  );
endinterface

// File: rtl/dual_port_ram_driver.sv
// Simple dual-port RAM driver with strobed read pipeline; DPRAM_WRITE_FIRST_EN selects write-first collisions.
// Latency: READ_LATENCY cycles from readclk sample to outclk sample, 1 word/cycle sustained.
// Backpressure: none, every outclk must be consumed; out holds between strobes.
module dual_port_ram_driver #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_SIZE     = 2048,
  parameter int READ_LATENCY = 2
) (
  input logic                   clk,
  input logic                   rst,
  dual_port_ram_driver_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(RAM_SIZE);
  localparam logic [ADDR_WIDTH:0] RAM_SIZE_W = (ADDR_WIDTH + 1)'(RAM_SIZE);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] dat;
  } stage_t;

  logic [DATA_WIDTH-1:0] mem [RAM_SIZE];
  stage_t                stage_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_in_range;
  logic                  wr_in_range;

  always_comb begin
    rd_in_range = {1'b0, bus.raddr} < RAM_SIZE_W;
    wr_in_range = {1'b0, bus.waddr} < RAM_SIZE_W;
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem[bus.raddr];
    end
`ifdef DPRAM_WRITE_FIRST_EN
    // Same-edge write to the read address wins: forward win into stage 1.
    if (bus.we && rd_in_range && (bus.waddr == bus.raddr)) begin
      rd_word = bus.win;
    end
`endif
  end

  // Storage carries no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.we && wr_in_range) begin
      mem[bus.waddr] <= bus.win;
    end
  end

  // Read data is captured at issue, so later writes cannot reach an in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0].vld <= bus.readclk;
      if (bus.readclk) begin
        stage_q[0].dat <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_q[i].vld <= stage_q[i-1].vld;
        if (stage_q[i-1].vld) begin
          stage_q[i].dat <= stage_q[i-1].dat;
        end
      end
    end
  end

  assign bus.outclk = stage_q[READ_LATENCY-1].vld;
  assign bus.out    = stage_q[READ_LATENCY-1].dat;
endmodule

// File: tb/tb_dual_port_ram_driver.sv
// Scoreboard bench: two configurations (2048x8 lat 2, 1000x12 lat 1) driven against an array model.
module tb_dual_port_ram_driver;
  localparam int LA = 2;
  localparam int LB = 1;
`ifdef DPRAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [63:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dual_port_ram_driver_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(11)) if_a ();
  dual_port_ram_driver_if #(.DATA_WIDTH(12), .ADDR_WIDTH(10)) if_b ();

  dual_port_ram_driver #(.DATA_WIDTH(8), .RAM_SIZE(2048), .READ_LATENCY(LA)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  dual_port_ram_driver #(.DATA_WIDTH(12), .RAM_SIZE(1000), .READ_LATENCY(LB)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  // Reference memories and expected-response queues.
  logic [7:0]  mdl_a [2048];
  logic [11:0] mdl_b [1024];
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  // Next-cycle stimulus, consumed by tick().
  bit         nrst = 1'b0;
  bit         a_rd, a_w, b_rd, b_w;
  int         a_ra, a_wa, b_ra, b_wa;
  logic [7:0]  a_wd;
  logic [11:0] b_wd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  task automatic tick();
    logic [63:0] x;
    @(negedge clk);
    #1;
    rst            = nrst;
    if_a.readclk   = a_rd;
    if_a.raddr     = 11'(a_ra);
    if_a.we        = a_w;
    if_a.waddr     = 11'(a_wa);
    if_a.win       = a_wd;
    if_b.readclk   = b_rd;
    if_b.raddr     = 10'(b_ra);
    if_b.we        = b_w;
    if_b.waddr     = 10'(b_wa);
    if_b.win       = b_wd;
    if (!nrst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_rd) begin
        x = (WF && a_w && a_wa == a_ra) ? 64'(a_wd) : 64'(mdl_a[a_ra]);
        qa.push_back('{cyc + LA, x});
      end
      if (b_rd) begin
        if (b_ra >= 1000) x = '0;
        else if (WF && b_w && b_wa == b_ra) x = 64'(b_wd);
        else x = 64'(mdl_b[b_ra]);
        qb.push_back('{cyc + LB, x});
      end
    end
    if (a_w) mdl_a[a_wa] = a_wd;
    if (b_w && b_wa < 1000) mdl_b[b_wa] = b_wd;
    a_rd = 1'b0; a_w = 1'b0; b_rd = 1'b0; b_w = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_rst_outclk", 64'(if_a.outclk), 64'(0));
      chk("a_rst_out", 64'(if_a.out), 64'(0));
      last_a = '0;
    end else if (if_a.outclk) begin
      if (qa.size() == 0) begin
        chk("a_outclk_without_request", 64'(if_a.outclk), 64'(0));
      end else begin
        ea = qa.pop_front();
        chk("a_strobe_cycle", 64'(cyc), 64'(ea.due));
        chk("a_read_data", 64'(if_a.out), ea.dat);
        last_a = ea.dat;
      end
    end else begin
      chk("a_out_hold", 64'(if_a.out), last_a);
      if (qa.size() != 0 && qa[0].due <= cyc) begin
        ea = qa.pop_front();
        chk("a_missing_outclk", 64'(if_a.outclk), 64'(1));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("b_rst_outclk", 64'(if_b.outclk), 64'(0));
      chk("b_rst_out", 64'(if_b.out), 64'(0));
      last_b = '0;
    end else if (if_b.outclk) begin
      if (qb.size() == 0) begin
        chk("b_outclk_without_request", 64'(if_b.outclk), 64'(0));
      end else begin
        eb = qb.pop_front();
        chk("b_strobe_cycle", 64'(cyc), 64'(eb.due));
        chk("b_read_data", 64'(if_b.out), eb.dat);
        last_b = eb.dat;
      end
    end else begin
      chk("b_out_hold", 64'(if_b.out), last_b);
      if (qb.size() != 0 && qb[0].due <= cyc) begin
        eb = qb.pop_front();
        chk("b_missing_outclk", 64'(if_b.outclk), 64'(1));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    if_a.readclk = 1'b0; if_a.raddr = '0; if_a.we = 1'b0; if_a.waddr = '0; if_a.win = '0;
    if_b.readclk = 1'b0; if_b.raddr = '0; if_b.we = 1'b0; if_b.waddr = '0; if_b.win = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held with read strobes toggling.
    nrst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_rd = i[0]; a_ra = i; b_rd = ~i[0]; b_ra = i;
      tick();
    end
    nrst = 1'b1;
    idle(2);

    // Fill 0..255, then stream reads back-to-back.
    for (int i = 0; i < 256; i++) begin
      a_w = 1'b1; a_wa = i; a_wd = 8'(i);
      b_w = 1'b1; b_wa = i; b_wd = 12'($urandom);
      tick();
    end
    for (int i = 0; i < 256; i++) begin
      a_rd = 1'b1; a_ra = i;
      b_rd = 1'b1; b_ra = i;
      tick();
    end
    idle(4);

    // Same-edge collision on address 5, then a plain re-read.
    a_w = 1'b1; a_wa = 5; a_wd = 8'h11; b_w = 1'b1; b_wa = 5; b_wd = 12'h111;
    tick();
    a_w = 1'b1; a_wa = 5; a_wd = 8'h22; a_rd = 1'b1; a_ra = 5;
    b_w = 1'b1; b_wa = 5; b_wd = 12'h222; b_rd = 1'b1; b_ra = 5;
    tick();
    a_rd = 1'b1; a_ra = 5; b_rd = 1'b1; b_ra = 5;
    tick();
    idle(3);

    // Write landing while a read of the same word is in flight.
    a_w = 1'b1; a_wa = 7; a_wd = 8'h33; b_w = 1'b1; b_wa = 7; b_wd = 12'h333;
    tick();
    a_rd = 1'b1; a_ra = 7; b_rd = 1'b1; b_ra = 7;
    tick();
    a_w = 1'b1; a_wa = 7; a_wd = 8'h44; b_w = 1'b1; b_wa = 7; b_wd = 12'h444;
    tick();
    idle(2);
    a_rd = 1'b1; a_ra = 7; b_rd = 1'b1; b_ra = 7;
    tick();
    idle(3);

    // Reset arriving while reads are in flight on the latency-2 port.
    a_rd = 1'b1; a_ra = 1;
    tick();
    nrst = 1'b0; a_rd = 1'b1; a_ra = 2;
    tick();
    a_rd = 1'b1; a_ra = 3;
    tick();
    idle(2);
    nrst = 1'b1;
    idle(5);
    for (int i = 0; i < 10; i++) begin
      a_rd = 1'b1; a_ra = i; b_rd = 1'b1; b_ra = i;
      tick();
    end
    idle(3);

    // Last in-range word versus an out-of-range address.
    b_w = 1'b1; b_wa = 999;  b_wd = 12'hABC;
    tick();
    b_w = 1'b1; b_wa = 1010; b_wd = 12'hABC;
    tick();
    b_rd = 1'b1; b_ra = 999;
    tick();
    b_rd = 1'b1; b_ra = 1010;
    tick();
    idle(3);

    // Random traffic over initialised and out-of-range regions.
    for (int i = 0; i < 2000; i++) begin
      a_rd = 1'($urandom); a_ra = int'($urandom_range(0, 255));
      a_w  = 1'($urandom); a_wa = int'($urandom_range(0, 255)); a_wd = 8'($urandom);
      b_rd = 1'($urandom);
      b_ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(999, 1023)) : int'($urandom_range(0, 255));
      b_w  = 1'($urandom);
      b_wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(999, 1023)) : int'($urandom_range(0, 255));
      b_wd = 12'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        b_ra = b_wa;
        a_ra = a_wa;
      end
      tick();
    end
    idle(LA + 4);

    chk("a_drain", 64'(qa.size()), 64'(0));
    chk("b_drain", 64'(qb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
